// File: rtl/mmio_bridge.sv
// mmio_bridge: routes CPU byte accesses either to RAM (combinational passthrough)
// or to the I/O page at 0x30000, which holds the UART TX/RX FIFOs, a free-running
// cycle counter with a coherent 32-bit snapshot, and a sticky program-stop flag.
module mmio_bridge #(
    parameter int TX_LOG = 4,
    parameter int RX_LOG = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [16:0] ram_a,
    output logic        ram_en,
    output logic        ram_wr,
    output logic [7:0]  ram_dout,
    input  logic [7:0]  ram_din,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        program_done
);
    localparam int TX_DEPTH = 1 << TX_LOG;
    localparam int RX_DEPTH = 1 << RX_LOG;

    logic [17:0] addr;
    logic        io;
    logic        io_rd;
    logic        io_wr;
    logic        rd_rx;
    logic        rd_cnt_lo;
    logic        rd_cnt_hi;
    logic        wr_tx;
    logic        wr_stop;

    assign addr      = mem_a[17:0];
    assign io        = (addr[17:16] == 2'b11);
    assign io_rd     = rdy_in & io & ~mem_wr;
    assign io_wr     = rdy_in & io & mem_wr;
    assign rd_rx     = io_rd & (addr == 18'h30000);
    assign rd_cnt_lo = io_rd & (addr == 18'h30004);
    assign rd_cnt_hi = io_rd & (addr[17:2] == 16'hC001) & (addr[1:0] != 2'b00);
    // A zero byte to the data port is swallowed so the UART never sees it.
    assign wr_tx     = io_wr & (addr == 18'h30000) & (mem_dout != 8'h00);
    assign wr_stop   = io_wr & (addr == 18'h30004);

    assign ram_a    = mem_a[16:0];
    assign ram_dout = mem_dout;
    assign ram_en   = rdy_in & ~io;
    assign ram_wr   = rdy_in & mem_wr & ~io;

    // The snapshot low byte is never read back (it is returned live), and the
    // upper address bits are outside the decoded window.
    logic unused_bits;

    // ---------------- TX FIFO ----------------
    logic [7:0]        tx_mem [TX_DEPTH];
    logic [TX_LOG-1:0] tx_wptr;
    logic [TX_LOG-1:0] tx_rptr;
    logic [TX_LOG:0]   tx_count;
    logic [TX_LOG:0]   tx_count_next;
    logic              tx_full;
    logic              tx_pop;
    logic              tx_push_ok;
    logic [7:0]        tx_push_data;

    assign tx_full      = (tx_count == (TX_LOG + 1)'(TX_DEPTH));
    assign tx_valid     = (tx_count != '0);
    assign tx_data      = tx_mem[tx_rptr];
    assign tx_pop       = rdy_in & tx_valid & tx_ready;
    // When full, a push is still accepted if the head leaves in the same cycle.
    assign tx_push_ok   = (wr_tx | wr_stop) & (~tx_full | tx_pop);
    assign tx_push_data = wr_stop ? 8'h00 : mem_dout;

    // Next TX occupancy, shared by the count register and the near-full flag.
    always_comb begin
        tx_count_next = tx_count;
        if (tx_push_ok && !tx_pop) begin
            tx_count_next = tx_count + 1'b1;
        end else if (!tx_push_ok && tx_pop) begin
            tx_count_next = tx_count - 1'b1;
        end
    end

    // TX pointers, occupancy and the registered near-full indication.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tx_wptr        <= '0;
            tx_rptr        <= '0;
            tx_count       <= '0;
            io_buffer_full <= 1'b0;
        end else if (rdy_in) begin
            if (tx_push_ok) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)     tx_rptr <= tx_rptr + 1'b1;
            tx_count       <= tx_count_next;
            io_buffer_full <= (tx_count_next >= (TX_LOG + 1)'(TX_DEPTH - 2));
        end
    end

    // TX storage; contents are meaningless until the pointers cover them.
    always_ff @(posedge clk_in) begin
        if (tx_push_ok) tx_mem[tx_wptr] <= tx_push_data;
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]        rx_mem [RX_DEPTH];
    logic [RX_LOG-1:0] rx_wptr;
    logic [RX_LOG-1:0] rx_rptr;
    logic [RX_LOG:0]   rx_count;
    logic              rx_empty;
    logic              rx_push;
    logic              rx_pop;

    assign rx_empty = (rx_count == '0);
    assign rx_ready = (rx_count != (RX_LOG + 1)'(RX_DEPTH));
    assign rx_push  = rdy_in & rx_valid & rx_ready;
    assign rx_pop   = rd_rx & ~rx_empty;

    // RX pointers and occupancy; simultaneous push and pop cancel out.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
        end else if (rdy_in) begin
            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
            if (rx_push && !rx_pop) begin
                rx_count <= rx_count + 1'b1;
            end else if (!rx_push && rx_pop) begin
                rx_count <= rx_count - 1'b1;
            end
        end
    end

    // RX storage.
    always_ff @(posedge clk_in) begin
        if (rx_push) rx_mem[rx_wptr] <= rx_data;
    end

    // ---------------- I/O registers and read return ----------------
    logic        io_q;
    logic [7:0]  io_rdata_q;
    logic [7:0]  io_rdata_next;
    logic [31:0] cycle_cnt;
    logic [31:0] cnt_snap;

    assign unused_bits = ^{mem_a[31:18], cnt_snap[7:0]};

    // Byte returned by an I/O read; the counter's upper bytes come from the
    // snapshot taken by the low-byte read so all four bytes are coherent.
    always_comb begin
        io_rdata_next = 8'h00;
        if (rd_rx) begin
            io_rdata_next = rx_empty ? 8'h00 : rx_mem[rx_rptr];
        end else if (rd_cnt_lo) begin
            io_rdata_next = cycle_cnt[7:0];
        end else if (rd_cnt_hi) begin
            case (addr[1:0])
                2'd1:    io_rdata_next = cnt_snap[15:8];
                2'd2:    io_rdata_next = cnt_snap[23:16];
                default: io_rdata_next = cnt_snap[31:24];
            endcase
        end
    end

    // Read-source select, read data, counter, snapshot and stop flag.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            io_q         <= 1'b0;
            io_rdata_q   <= 8'h00;
            cycle_cnt    <= '0;
            cnt_snap     <= '0;
            program_done <= 1'b0;
        end else if (rdy_in) begin
            io_q      <= io & ~mem_wr;
            cycle_cnt <= cycle_cnt + 32'd1;
            if (io_rd)     io_rdata_q   <= io_rdata_next;
            if (rd_cnt_lo) cnt_snap     <= cycle_cnt;
            if (wr_stop)   program_done <= 1'b1;
        end
    end

    assign mem_din = io_q ? io_rdata_q : ram_din;

endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge: table-driven RAM/I/O vectors plus
// hand-written sequences, with read and TX scoreboards.
module tb_mmio_bridge;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [16:0] ram_a;
    logic        ram_en;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        program_done;

    always #5 clk_in = ~clk_in;

    mmio_bridge #(.TX_LOG(4), .RX_LOG(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
        .io_buffer_full(io_buffer_full),
        .ram_a(ram_a), .ram_en(ram_en), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .program_done(program_done)
    );

    int checks = 0;
    int errors = 0;
    int tx_pops = 0;
    bit pend = 1'b0;
    logic [7:0] rd_exp [$];
    string      rd_nm [$];
    logic [7:0] tx_exp [$];

    // RAM model with one-cycle read latency
    logic [7:0] ram_mem [0:1023];
    logic [7:0] ram_rd = 8'h00;
    assign ram_din = ram_rd;
    always @(posedge clk_in) begin
        if (ram_en && ram_wr) ram_mem[ram_a[9:0]] <= ram_dout;
        if (ram_en) ram_rd <= ram_mem[ram_a[9:0]];
    end

    // Reference cycle counter
    logic [31:0] mcnt = 32'd0;
    always @(posedge clk_in) begin
        if (rst_in) mcnt <= 32'd0;
        else if (rdy_in) mcnt <= mcnt + 32'd1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h required %0h", nm, act, exp);
        end
    endtask

    // TX monitor: a byte leaves at the next rising edge when this holds
    always @(negedge clk_in) begin
        if (!rst_in && rdy_in && tx_valid && tx_ready) begin
            tx_pops++;
            if (tx_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_extra got %0h required none", tx_data);
            end else begin
                check("tx_data", {24'd0, tx_data}, {24'd0, tx_exp.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
        if (pend) begin
            pend = 1'b0;
            check(rd_nm.pop_front(), {24'd0, mem_din}, {24'd0, rd_exp.pop_front()});
        end
    endtask

    task automatic push_tx(input logic [7:0] v);
        if (tx_exp.size() < 16 || (tx_ready && tx_exp.size() > 0)) tx_exp.push_back(v);
    endtask

    task automatic drive(input bit wr, input logic [31:0] a, input logic [7:0] d,
                         input bit chk, input logic [7:0] exp, input string nm);
        mem_wr = wr;
        mem_a = a;
        mem_dout = d;
        if (wr && rdy_in && !rst_in && a[17:16] == 2'b11) begin
            if (a[17:0] == 18'h30000 && d != 8'h00) push_tx(d);
            else if (a[17:0] == 18'h30004) push_tx(8'h00);
        end
        if (!wr && chk) begin
            rd_exp.push_back(exp);
            rd_nm.push_back(nm);
            pend = 1'b1;
        end
    endtask

    task automatic op(input bit wr, input logic [31:0] a, input logic [7:0] d,
                      input bit chk, input logic [7:0] exp, input string nm);
        drive(wr, a, d, chk, exp, nm);
        tick();
    endtask

    task automatic idle(input int n);
        mem_wr = 1'b0;
        mem_a = 32'd0;
        mem_dout = 8'h00;
        repeat (n) tick();
    endtask

    task automatic drain(input int max_cycles);
        tx_ready = 1'b1;
        idle(1);
        for (int i = 0; i < max_cycles && tx_valid; i++) tick();
        check("tx_drained", {31'd0, tx_valid}, 32'd0);
        check("tx_left", tx_exp.size(), 32'd0);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [7:0]  d;
        logic [7:0]  exp;
    } vec_t;

    vec_t vt [8];

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1);
    end

    initial begin
        int pops0;
        logic io;
        vt[0] = '{1'b1, 32'h0000_0100, 8'hA5, 8'h00};
        vt[1] = '{1'b0, 32'h0000_0100, 8'h00, 8'hA5};
        vt[2] = '{1'b1, 32'h0001_FFFF, 8'h3C, 8'h00};
        vt[3] = '{1'b0, 32'hABC1_FFFF, 8'h00, 8'h3C};
        vt[4] = '{1'b0, 32'h0003_0008, 8'h00, 8'h00};
        vt[5] = '{1'b0, 32'h0003_0000, 8'h00, 8'h00};
        vt[6] = '{1'b1, 32'h0003_0005, 8'h77, 8'h00};
        vt[7] = '{1'b0, 32'h0000_0100, 8'h00, 8'hA5};

        for (int i = 0; i < 1024; i++) ram_mem[i] = 8'h00;
        rst_in = 1'b1; rdy_in = 1'b1; mem_a = 32'd0; mem_dout = 8'h00; mem_wr = 1'b0;
        tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        repeat (3) tick();
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        check("rst_buf_full", {31'd0, io_buffer_full}, 32'd0);
        check("rst_done", {31'd0, program_done}, 32'd0);
        check("rst_mem_din", {24'd0, mem_din}, {24'd0, ram_din});
        rst_in = 1'b0;

        // Table: RAM passthrough and simple I/O decode
        for (int i = 0; i < 8; i++) begin
            drive(vt[i].wr, vt[i].a, vt[i].d, 1'b1, vt[i].exp, "tbl_rd");
            #1;
            io = (vt[i].a[17:16] == 2'b11);
            check("tbl_ram_en", {31'd0, ram_en}, {31'd0, !io});
            check("tbl_ram_wr", {31'd0, ram_wr}, {31'd0, vt[i].wr && !io});
            check("tbl_ram_a", {15'd0, ram_a}, {15'd0, vt[i].a[16:0]});
            check("tbl_ram_dout", {24'd0, ram_dout}, {24'd0, vt[i].d});
            tick();
        end
        check("tbl_no_tx", {31'd0, tx_valid}, 32'd0);

        // UART output: the zero byte is swallowed
        tx_ready = 1'b1;
        pops0 = tx_pops;
        op(1'b1, 32'h30000, 8'h41, 1'b0, 8'h00, "");
        check("uart_valid_41", {31'd0, tx_valid}, 32'd1);
        op(1'b1, 32'h30000, 8'h00, 1'b0, 8'h00, "");
        check("uart_valid_00", {31'd0, tx_valid}, 32'd0);
        op(1'b1, 32'h30000, 8'h42, 1'b0, 8'h00, "");
        check("uart_valid_42", {31'd0, tx_valid}, 32'd1);
        idle(2);
        check("uart_pops", tx_pops - pops0, 32'd2);
        check("uart_left", tx_exp.size(), 32'd0);

        // Counter coherence across four byte reads
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        for (int i = 0; i < 2000 && mcnt != 32'h1FF; i++) tick();
        if (mcnt != 32'h1FF) begin
            checks++; errors++;
            $display("FAIL cnt_wait got %0h required 1ff", mcnt);
        end
        op(1'b0, 32'h30004, 8'h00, 1'b1, 8'hFF, "cnt_b0");
        op(1'b0, 32'h30005, 8'h00, 1'b1, 8'h01, "cnt_b1");
        op(1'b0, 32'h30006, 8'h00, 1'b1, 8'h00, "cnt_b2");
        op(1'b0, 32'h30007, 8'h00, 1'b1, 8'h00, "cnt_b3");
        drive(1'b0, 32'h30004, 8'h00, 1'b1, mcnt[7:0], "cnt_live");
        tick();

        // TX backpressure: near-full after 14, 17th dropped, drain 16 in order
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            op(1'b1, 32'h30000, 8'h10 + 8'(i), 1'b0, 8'h00, "");
            if (i == 12) check("bp_full_13", {31'd0, io_buffer_full}, 32'd0);
            if (i == 13) check("bp_full_14", {31'd0, io_buffer_full}, 32'd1);
        end
        op(1'b1, 32'h30000, 8'h99, 1'b0, 8'h00, "");
        check("bp_full_17", {31'd0, io_buffer_full}, 32'd1);
        pops0 = tx_pops;
        drain(40);
        check("bp_pops", tx_pops - pops0, 32'd16);
        check("bp_full_end", {31'd0, io_buffer_full}, 32'd0);

        // RX FIFO basic, coincident push/pop, and full
        tx_ready = 1'b0;
        rx_valid = 1'b1; rx_data = 8'h31;
        idle(1);
        rx_data = 8'h32;
        idle(1);
        rx_valid = 1'b0;
        op(1'b0, 32'h30000, 8'h00, 1'b1, 8'h31, "rx_1");
        op(1'b0, 32'h30000, 8'h00, 1'b1, 8'h32, "rx_2");
        op(1'b0, 32'h30000, 8'h00, 1'b1, 8'h00, "rx_empty");
        rx_valid = 1'b1; rx_data = 8'h55;
        idle(1);
        rx_data = 8'h66;
        op(1'b0, 32'h30000, 8'h00, 1'b1, 8'h55, "rx_same_a");
        rx_valid = 1'b0;
        op(1'b0, 32'h30000, 8'h00, 1'b1, 8'h66, "rx_same_b");
        op(1'b0, 32'h30000, 8'h00, 1'b1, 8'h00, "rx_same_c");
        rx_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rx_data = 8'h80 + 8'(i);
            idle(1);
        end
        check("rx_full_ready", {31'd0, rx_ready}, 32'd0);
        rx_data = 8'hEE;
        idle(1);
        rx_valid = 1'b0;
        for (int i = 0; i < 16; i++) op(1'b0, 32'h30000, 8'h00, 1'b1, 8'h80 + 8'(i), "rx_full_rd");
        op(1'b0, 32'h30000, 8'h00, 1'b1, 8'h00, "rx_full_drop");
        check("rx_ready_back", {31'd0, rx_ready}, 32'd1);

        // Stop flag and freeze
        op(1'b1, 32'h30004, 8'hAB, 1'b0, 8'h00, "");
        check("stop_done", {31'd0, program_done}, 32'd1);
        check("stop_tx_valid", {31'd0, tx_valid}, 32'd1);
        rdy_in = 1'b0;
        tx_ready = 1'b1;
        mem_wr = 1'b1; mem_a = 32'h0000_0200; mem_dout = 8'h5A;
        #1;
        check("frz_ram_en", {31'd0, ram_en}, 32'd0);
        check("frz_ram_wr", {31'd0, ram_wr}, 32'd0);
        mem_a = 32'h30000; mem_dout = 8'h77;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("frz_tx_valid", {31'd0, tx_valid}, 32'd1);
        end
        rdy_in = 1'b1;
        mem_wr = 1'b0; mem_a = 32'd0;
        drive(1'b0, 32'h30004, 8'h00, 1'b1, mcnt[7:0], "frz_cnt");
        tick();
        drain(10);

        // Reset mid-stream discards FIFO contents and pending read data
        tx_ready = 1'b0;
        op(1'b1, 32'h30000, 8'h51, 1'b0, 8'h00, "");
        op(1'b1, 32'h30000, 8'h52, 1'b0, 8'h00, "");
        rx_valid = 1'b1; rx_data = 8'h77;
        idle(1);
        rx_valid = 1'b0;
        op(1'b0, 32'h30000, 8'h00, 1'b1, 8'h77, "mid_rd");
        rst_in = 1'b1;
        tx_exp.delete();
        idle(1);
        check("mid_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("mid_rx_ready", {31'd0, rx_ready}, 32'd1);
        check("mid_buf_full", {31'd0, io_buffer_full}, 32'd0);
        check("mid_done", {31'd0, program_done}, 32'd0);
        check("mid_mem_din", {24'd0, mem_din}, {24'd0, ram_din});
        rst_in = 1'b0;
        op(1'b0, 32'h30000, 8'h00, 1'b1, 8'h00, "mid_rx_flushed");
        drive(1'b0, 32'h30004, 8'h00, 1'b1, mcnt[7:0], "mid_cnt");
        tick();
        tx_ready = 1'b1;
        idle(2);
        check("mid_tx_idle", {31'd0, tx_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
